// File: rtl/crc33_frame_sched.sv
// Round-robin frame scheduler sharing one external combinational CRC33 engine between two requesters;
// one IDLE cycle precedes each frame, beats stream at 1/cycle, and an unconsumed result stalls both requesters.
module crc33_frame_sched #(
  parameter logic [32:0] INIT   = 33'h1_FFFF_FFFF,
  parameter logic [32:0] XOROUT = 33'h0_0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [263:0] req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [263:0] req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic [263:0] eng_data,
  output logic [32:0]  eng_crc,
  input  logic [32:0]  eng_next,
  output logic         res_valid,
  output logic [32:0]  res_crc,
  output logic         res_src,
  output logic [15:0]  res_beats,
  input  logic         res_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESULT = 2'd2} state_t;

  typedef struct packed {
    logic [32:0] crc;
    logic        src;
    logic [15:0] beats;
  } res_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;
  logic [32:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        res_vld_q, res_vld_d;
  res_t        res_q, res_d;

  logic         sel_valid;
  logic         sel_last;
  logic [263:0] sel_data;
  logic [15:0]  cnt_inc;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_last  = grant_q ? req1_last  : req0_last;
  assign sel_data  = grant_q ? req1_data  : req0_data;
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    res_vld_d  = res_vld_q;
    res_d      = res_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    eng_data   = '0;
    eng_crc    = crc_q;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Preferred requester wins if valid, otherwise the other one must be the valid one.
          grant_d = rr_q ? req1_valid : ~req0_valid;
          state_d = BUSY;
        end
        crc_d = INIT;
        cnt_d = '0;
      end
      BUSY: begin
        req0_ready = ~grant_q;
        req1_ready = grant_q;
        eng_data   = sel_data;
        if (sel_valid) begin
          crc_d = eng_next;
          cnt_d = cnt_inc;
          if (sel_last) begin
            res_d.crc   = eng_next ^ XOROUT;
            res_d.src   = grant_q;
            res_d.beats = cnt_inc;
            res_vld_d   = 1'b1;
            state_d     = RESULT;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_vld_d = 1'b0;
          rr_d      = ~res_q.src;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      crc_q     <= INIT;
      cnt_q     <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
    end
  end

  assign res_valid = res_vld_q;
  assign res_crc   = res_q.crc;
  assign res_src   = res_q.src;
  assign res_beats = res_q.beats;

endmodule

// File: doc/crc33_frame_sched.md
Name: crc33_frame_sched

Overview:
- Frame-level scheduler that shares one combinational 264-bit-data CRC33 engine between two requesters.
- Arbitrates per frame with round-robin priority and streams 264-bit beats through the external engine at one beat per cycle.
- Holds the running CRC register and presents the final CRC plus the source ID on a valid/ready result port.
- Sits between the packet framers and the CRC33 engine. The engine itself is external and connects via the eng_* ports.

Parameters:
- INIT, 33'h1_FFFF_FFFF, CRC register value loaded at the start of every frame.
- XOROUT, 33'h0_0000_0000, value XORed into the final CRC before it is presented.

Ports:
- clk  in  1  single clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 beat valid.
- req0_data  in  264  requester 0 beat; bit 263 is the first serial bit.
- req0_last  in  1  marks the last beat of a requester 0 frame.
- req0_ready  out  1  requester 0 beat accepted.
- req1_valid, req1_data, req1_last, req1_ready: same as requester 0, for requester 1.
- eng_data  out  264  data to the engine (granted requester's data, else 0).
- eng_crc  out  33  current CRC register to the engine.
- eng_next  in  33  engine result; purely combinational from eng_data/eng_crc.
- res_valid  out  1  result available.
- res_crc  out  33  final CRC value.
- res_src  out  1  requester that produced the result.
- res_beats  out  16  beats in the frame, saturating at 16'hFFFF.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset, asynchronous: state=IDLE, crc_reg=INIT, rr_ptr=0 (requester 0 preferred), beat_cnt=0, res_valid=0, res_crc=0, res_src=0, res_beats=0, both reqN_ready=0. A reset asserted mid-frame or mid-result abandons that frame; no result is issued for it.
- States: IDLE, BUSY, RESULT.
- IDLE:
  - reqN_ready=0.
  - If any reqN_valid: grant <= the preferred requester if it is valid, else the other one.
  - crc_reg <= INIT, beat_cnt <= 0, go to BUSY.
  - No beat is accepted in the IDLE cycle, so a valid-to-first-accept latency of 1 cycle is the minimum.
- BUSY:
  - req[grant]_ready=1; the other requester's ready=0.
  - eng_data=req[grant]_data, eng_crc=crc_reg.
  - On req[grant]_valid (a beat transfers):
    - crc_reg <= eng_next.
    - beat_cnt <= beat_cnt+1, saturating.
    - If req[grant]_last: res_crc <= eng_next ^ XOROUT, res_src <= grant, res_beats <= beat_cnt+1 (saturating), res_valid <= 1, go to RESULT.
  - Valid low means a bubble: the state holds and crc_reg is unchanged.
  - Throughput is 1 beat per cycle.
  - The grant is locked for the whole frame; the other requester's valid is ignored until the frame ends.
- RESULT:
  - reqN_ready=0; res_* are held stable while res_valid=1 and res_ready=0.
  - On res_ready: res_valid <= 0, rr_ptr <= ~res_src, go to IDLE. The next grant decision is made in that IDLE cycle.
  - res_ready asserted in the same cycle res_valid rises takes effect on the following edge; res_valid is high for at least 1 cycle.
- Outside BUSY, eng_data=0 and eng_crc=crc_reg.
- Both requesters valid in IDLE: rr_ptr decides; after each frame the served requester loses priority.
- A single-beat frame (last on the first beat): the result is registered on that beat with res_beats=1.
- reqN_last is ignored when reqN_valid=0.

Test Plan:
The bench connects eng_* to the team's CRC33 264-bit combinational engine. Defaults are INIT and XOROUT as above.
- Single-beat frame, req0_data=0, last=1 -> req0_ready high in the cycle after valid; res_crc=33'h0_0200_0000, res_src=0, res_beats=1.
- Two-beat frame on req1, both beats 0 -> res_crc=33'h0_0002_0000, res_src=1, res_beats=2.
- Parameter override INIT=0, one zero beat -> res_crc=0. Then XOROUT=33'h1_FFFF_FFFF with the same stimulus -> res_crc=33'h1_FFFF_FFFF.
- Both requesters continuously valid with 3-beat frames, res_ready=1 -> order of res_src is 0,1,0,1; the non-granted requester's ready never asserts during the other's frame.
- res_ready held low for 5 cycles -> res_* stable, both readies 0, and a new frame on req0 is not granted until 1 cycle after res_ready rises.
- Reset pulsed mid-BUSY after 2 beats -> readies drop immediately, res_valid stays 0, crc_reg returns to INIT. The next zero single-beat frame yields 33'h0_0200_0000.
